// File: rtl/regfile_param_dump.sv
`default_nettype none
// ============================================================================
// Module      : regfile_param_dump
// Description : Parametrised general-purpose register file (WIDTH x DEPTH)
//               with two registered read ports, one write port with an
//               optional register-pair write, a flat all_registers view and
//               a valid/ready debug-dump sequencer that streams every
//               register out, one register per accepted beat.
// Ports       : clock, clr_n (async active-low reset)
//               RA1, RA2 / RD1, RD2       registered read ports
//               WA, RegWrite, PairWrite,
//               WD, WD_hi                 write port (WD_hi = pair high half)
//               dump_start, dump_ready    dump request / sink back-pressure
//               dump_valid, dump_addr,
//               dump_data, dump_busy,
//               dump_done                 dump stream and status
//               all_registers             flat storage view, reg i at
//                                         [i*WIDTH +: WIDTH]
// Options     : define REGFILE_BYPASS_EN to make read ports and dump beats
//               capture data written at the same edge (write-through).
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_param_dump #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clock,
    input  logic                     clr_n,
    input  logic [ADDR_W-1:0]        RA1,
    input  logic [ADDR_W-1:0]        RA2,
    input  logic [ADDR_W-1:0]        WA,
    input  logic                     RegWrite,
    input  logic                     PairWrite,
    input  logic [WIDTH-1:0]         WD,
    input  logic [WIDTH-1:0]         WD_hi,
    output logic [WIDTH-1:0]         RD1,
    output logic [WIDTH-1:0]         RD2,
    input  logic                     dump_start,
    input  logic                     dump_ready,
    output logic                     dump_valid,
    output logic [ADDR_W-1:0]        dump_addr,
    output logic [WIDTH-1:0]         dump_data,
    output logic                     dump_busy,
    output logic                     dump_done,
    output logic [DEPTH*WIDTH-1:0]   all_registers
);

    // Dump sequencer states
    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_send = 1'b1;

    localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(DEPTH - 1);

    // Storage kept as a packed array so the flat view is a direct alias.
    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [DEPTH-1:0][WIDTH-1:0] w_next;   // storage contents after this edge
    logic [DEPTH-1:0][WIDTH-1:0] w_rd_src; // what reads/dump sample from

    logic [WIDTH-1:0]  r_rd1;
    logic [WIDTH-1:0]  r_rd2;
    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [WIDTH-1:0]  r_dump_data;
    logic              r_dump_valid;
    logic              r_dump_busy;
    logic              r_dump_done;

    logic [ADDR_W-1:0] w_dump_rd_addr;
    logic [WIDTH-1:0]  w_dump_rd_data;

    // Address decode by full comparison against each implemented index, so
    // addresses at or above DEPTH match nothing: writes drop, reads give 0.
    function automatic logic [WIDTH-1:0] f_read(
        input logic [ADDR_W-1:0]             addr,
        input logic [DEPTH-1:0][WIDTH-1:0]   src
    );
        f_read = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr == ADDR_W'(i)) begin
                f_read = src[i];
            end
        end
    endfunction

    // Next storage state. A pair write targets the even/odd couple sharing
    // WA's upper bits; since DEPTH is even a pair is either fully in range
    // or fully out of range.
    always_comb begin
        w_next = r_mem;
        if (RegWrite) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (PairWrite) begin
                    if ((WA >> 1) == (ADDR_W'(i) >> 1)) begin
                        w_next[i] = ((i % 2) == 1) ? WD_hi : WD;
                    end
                end else if (WA == ADDR_W'(i)) begin
                    w_next[i] = WD;
                end
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign w_rd_src = w_next;
`else
    assign w_rd_src = r_mem;
`endif

    // Register the dump samples on this edge: reg[0] when starting,
    // reg[ptr+1] when a beat is being accepted.
    assign w_dump_rd_addr = (r_state == c_st_idle) ? '0 : (r_ptr + 1'b1);
    assign w_dump_rd_data = f_read(w_dump_rd_addr, w_rd_src);

    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            r_mem        <= '0;
            r_rd1        <= '0;
            r_rd2        <= '0;
            r_state      <= c_st_idle;
            r_ptr        <= '0;
            r_dump_data  <= '0;
            r_dump_valid <= 1'b0;
            r_dump_busy  <= 1'b0;
            r_dump_done  <= 1'b0;
        end else begin
            r_mem       <= w_next;
            r_rd1       <= f_read(RA1, w_rd_src);
            r_rd2       <= f_read(RA2, w_rd_src);
            r_dump_done <= 1'b0;

            case (r_state)
                c_st_idle: begin
                    if (dump_start) begin
                        r_ptr        <= '0;
                        r_dump_data  <= w_dump_rd_data;
                        r_dump_valid <= 1'b1;
                        r_dump_busy  <= 1'b1;
                        r_state      <= c_st_send;
                    end
                end
                c_st_send: begin
                    // dump_valid is always high here; without ready the beat
                    // simply holds, independent of writes to that register.
                    if (dump_ready) begin
                        if (r_ptr == c_last_idx) begin
                            r_dump_valid <= 1'b0;
                            r_dump_busy  <= 1'b0;
                            r_dump_done  <= 1'b1;
                            r_state      <= c_st_idle;
                        end else begin
                            r_ptr       <= r_ptr + 1'b1;
                            r_dump_data <= w_dump_rd_data;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign RD1           = r_rd1;
    assign RD2           = r_rd2;
    assign dump_valid    = r_dump_valid;
    assign dump_addr     = r_ptr;
    assign dump_data     = r_dump_data;
    assign dump_busy     = r_dump_busy;
    assign dump_done     = r_dump_done;
    assign all_registers = r_mem;

endmodule
`default_nettype wire
